// File: rtl/mem_int.sv
// ---------------------------------------------------------------------------
// mem_int
// Database-scan front end for the BLAST seed search. A query pulse starts a
// scan over NUM_LINES database lines held in DDR. Each line is fetched with
// a request/acknowledge/valid handshake. The line is then searched at every
// base-aligned (even bit) offset for the query word. The bit-address span of
// the first match is reported, or all-ones if no line contains the query.
//
// Ports
//   clk            system clock, rising edge
//   rst            asynchronous active-high reset
//   ddr_rd         read request, held until ddr_rd_done
//   ddr_rd_done    request acknowledge (may be combinational with ddr_rd)
//   readAdd        bit address of the requested line
//   ddr_rd_valid   ddr_rd_data valid this cycle
//   ddr_rd_data    returned database line
//   query          query; only the low QUERY_BITS bits are used
//   queryValid     one-cycle start pulse, query sampled in the same cycle
//   locationStart  bit address of the match LSB (all-ones when no hit)
//   locationEnd    locationStart + QUERY_BITS - 1 (all-ones when no hit)
//   hitTEST        match-found flag
// ---------------------------------------------------------------------------
module mem_int #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    LINE_BITS  = 512,
    parameter int                    QUERY_BITS = 32,
    parameter int                    NUM_LINES  = 100,
    parameter logic [ADDR_WIDTH-1:0] START_ADDR = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  ddr_rd,
    input  logic                  ddr_rd_done,
    output logic [ADDR_WIDTH-1:0] readAdd,
    input  logic                  ddr_rd_valid,
    input  logic [LINE_BITS-1:0]  ddr_rd_data,
    input  logic [LINE_BITS-1:0]  query,
    input  logic                  queryValid,
    output logic [ADDR_WIDTH-1:0] locationStart,
    output logic [ADDR_WIDTH-1:0] locationEnd,
    output logic                  hitTEST
);

    // Offsets 0, 2, ..., LINE_BITS-QUERY_BITS keep the whole query inside
    // one line; a match straddling two lines is never seen.
    localparam int NUM_OFFSETS = (LINE_BITS - QUERY_BITS) / 2 + 1;
    localparam int OFF_W       = $clog2(LINE_BITS);
    localparam int CNT_W       = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_CMP,
        S_DONE
    } state_t;

    state_t                  r_state;
    state_t                  w_nextState;

    logic                    r_ddrRd;
    logic [ADDR_WIDTH-1:0]   r_readAdd;
    logic [CNT_W-1:0]        r_lineCnt;
    logic [QUERY_BITS-1:0]   r_query;
    logic [LINE_BITS-1:0]    r_line;
    logic [ADDR_WIDTH-1:0]   r_locStart;
    logic [ADDR_WIDTH-1:0]   r_locEnd;
    logic                    r_hit;

    logic                    w_hit;
    logic [OFF_W-1:0]        w_hitOffset;
    logic                    w_lastLine;
    logic [ADDR_WIDTH-1:0]   w_matchStart;
    logic [ADDR_WIDTH-1:0]   w_matchEnd;
    logic                    w_unusedQueryBits;

    // Only the low query bits take part in the search.
    assign w_unusedQueryBits = ^query[LINE_BITS-1:QUERY_BITS];

    assign w_lastLine   = (r_lineCnt == CNT_W'(NUM_LINES - 1));
    assign w_matchStart = r_readAdd + ADDR_WIDTH'(w_hitOffset);
    assign w_matchEnd   = w_matchStart + ADDR_WIDTH'(QUERY_BITS - 1);

    // Parallel search over all base-aligned offsets. The scan runs from the
    // top down, so the lowest matching offset is the last one written and wins.
    always_comb begin
        w_hit       = 1'b0;
        w_hitOffset = '0;
        for (int i = NUM_OFFSETS - 1; i >= 0; i--) begin
            if (r_line[2*i +: QUERY_BITS] == r_query) begin
                w_hit       = 1'b1;
                w_hitOffset = OFF_W'(2 * i);
            end
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic. queryValid only matters once the previous scan has
    // finished or before any scan has started.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (queryValid) begin
                    w_nextState = S_REQ;
                end
            end
            S_REQ: begin
                if (ddr_rd_done) begin
                    w_nextState = S_WAIT;
                end
            end
            S_WAIT: begin
                if (ddr_rd_valid) begin
                    w_nextState = S_CMP;
                end
            end
            S_CMP: begin
                if (w_hit || w_lastLine) begin
                    w_nextState = S_DONE;
                end else begin
                    w_nextState = S_REQ;
                end
            end
            default: begin
                w_nextState = S_IDLE;
            end
        endcase
    end

    // Datapath. The read request is registered from the next state. With a
    // combinational acknowledge it is therefore a single-cycle pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ddrRd    <= 1'b0;
            r_readAdd  <= START_ADDR;
            r_lineCnt  <= '0;
            r_query    <= '0;
            r_line     <= '0;
            r_locStart <= '0;
            r_locEnd   <= '0;
            r_hit      <= 1'b0;
        end else begin
            r_ddrRd <= (w_nextState == S_REQ);
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (queryValid) begin
                        r_query   <= query[QUERY_BITS-1:0];
                        r_readAdd <= START_ADDR;
                        r_lineCnt <= '0;
                        r_hit     <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (ddr_rd_valid) begin
                        r_line <= ddr_rd_data;
                    end
                end
                S_CMP: begin
                    if (w_hit) begin
                        r_locStart <= w_matchStart;
                        r_locEnd   <= w_matchEnd;
                        r_hit      <= 1'b1;
                    end else if (w_lastLine) begin
                        r_locStart <= '1;
                        r_locEnd   <= '1;
                    end else begin
                        r_readAdd <= r_readAdd + ADDR_WIDTH'(LINE_BITS);
                        r_lineCnt <= r_lineCnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign ddr_rd        = r_ddrRd;
    assign readAdd       = r_readAdd;
    assign locationStart = r_locStart;
    assign locationEnd   = r_locEnd;
    assign hitTEST       = r_hit;

endmodule

// File: tb/tb_mem_int.sv
// ---------------------------------------------------------------------------
// tb_mem_int
// Self-checking bench for mem_int. A DDR responder serves lines from a local
// memory array. The acknowledge is tied to the request, and data returns
// after a programmable random delay. Expected results for random scans come
// from a plain linear search of that array.
// ---------------------------------------------------------------------------
module tb_mem_int;

    localparam int          NUM_LINES  = 100;
    localparam int          LINE_BITS  = 512;
    localparam logic [31:0] START_ADDR = 32'd0;
    localparam int          BUDGET     = 3000;

    logic                 clk;
    logic                 rst;
    logic                 ddr_rd;
    logic                 ddr_rd_done;
    logic [31:0]          readAdd;
    logic                 ddr_rd_valid;
    logic [LINE_BITS-1:0] ddr_rd_data;
    logic [LINE_BITS-1:0] query;
    logic                 queryValid;
    logic [31:0]          locationStart;
    logic [31:0]          locationEnd;
    logic                 hitTEST;

    logic [LINE_BITS-1:0] mem [0:NUM_LINES-1];

    int assertCount = 0;
    int failCount   = 0;
    int readCount   = 0;
    int pendingCnt  = -1;
    int pendingLine = 0;
    int maxDelay    = 0;
    bit junkEn      = 1'b0;

    mem_int #(
        .ADDR_WIDTH (32),
        .LINE_BITS  (LINE_BITS),
        .QUERY_BITS (32),
        .NUM_LINES  (NUM_LINES),
        .START_ADDR (START_ADDR)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .ddr_rd        (ddr_rd),
        .ddr_rd_done   (ddr_rd_done),
        .readAdd       (readAdd),
        .ddr_rd_valid  (ddr_rd_valid),
        .ddr_rd_data   (ddr_rd_data),
        .query         (query),
        .queryValid    (queryValid),
        .locationStart (locationStart),
        .locationEnd   (locationEnd),
        .hitTEST       (hitTEST)
    );

    // The acknowledge is combinational with the request.
    assign ddr_rd_done = ddr_rd;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        assertCount++;
        if (got !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [LINE_BITS-1:0] randomLine();
        logic [LINE_BITS-1:0] l;
        for (int w = 0; w < LINE_BITS / 32; w++) begin
            l[32*w +: 32] = $urandom;
        end
        return l;
    endfunction

    // First occurrence of q at an even bit offset, searching line by line.
    task automatic refScan(input logic [31:0] q, output bit hit, output logic [31:0] start, output int reads);
        hit   = 1'b0;
        start = 32'hFFFF_FFFF;
        reads = NUM_LINES;
        for (int ln = 0; ln < NUM_LINES && !hit; ln++) begin
            for (int k = 0; k + 32 <= LINE_BITS && !hit; k += 2) begin
                if (mem[ln][k +: 32] == q) begin
                    hit   = 1'b1;
                    start = START_ADDR + 32'(ln * LINE_BITS + k);
                    reads = ln + 1;
                end
            end
        end
    endtask

    // DDR responder and read monitor. Every request is checked against the
    // expected address sequence. Its line is returned after 0..maxDelay
    // extra cycles. When junkEn is set, stray valid pulses carrying random
    // data appear while no read is outstanding.
    initial begin
        ddr_rd_valid = 1'b0;
        ddr_rd_data  = '0;
        forever begin
            @(negedge clk);
            ddr_rd_valid = 1'b0;
            ddr_rd_data  = randomLine();
            if (rst) begin
                pendingCnt = -1;
            end else begin
                if (pendingCnt == 0) begin
                    ddr_rd_valid = 1'b1;
                    ddr_rd_data  = (pendingLine < NUM_LINES) ? mem[pendingLine] : '0;
                    pendingCnt   = -1;
                end else if (pendingCnt > 0) begin
                    pendingCnt--;
                end else if (junkEn && !ddr_rd && $urandom_range(0, 3) == 0) begin
                    ddr_rd_valid = 1'b1;
                end
                if (ddr_rd) begin
                    checkOutput("readAdd", readAdd, START_ADDR + 32'(readCount * LINE_BITS));
                    readCount++;
                    pendingLine = int'(readAdd >> 9);
                    pendingCnt  = (maxDelay == 0) ? 0 : int'($urandom_range(0, maxDelay));
                end
            end
        end
    end

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, ".ddr_rd"}, 32'(ddr_rd), 32'd0);
        checkOutput({tag, ".readAdd"}, readAdd, START_ADDR);
        checkOutput({tag, ".hitTEST"}, 32'(hitTEST), 32'd0);
        checkOutput({tag, ".locStart"}, locationStart, 32'd0);
        checkOutput({tag, ".locEnd"}, locationEnd, 32'd0);
    endtask

    // Starts a scan for q, optionally re-pulses queryValid while the first
    // read is outstanding, then waits for the scan to finish and checks the
    // result.
    task automatic applyStimulus(input logic [31:0] q, input bit expHit, input logic [31:0] expStart,
                                 input int expReads, input bit repulse, input string tag);
        int budget;
        logic [31:0] expEnd;
        expEnd = expHit ? expStart + 32'd31 : 32'hFFFF_FFFF;
        @(negedge clk);
        readCount  = 0;
        query      = randomLine();
        query[31:0] = q;
        queryValid = 1'b1;
        @(negedge clk);
        queryValid = 1'b0;
        #1;
        checkOutput({tag, ".hitClear"}, 32'(hitTEST), 32'd0);
        checkOutput({tag, ".firstAdd"}, readAdd, START_ADDR);
        checkOutput({tag, ".rdHigh"}, 32'(ddr_rd), 32'd1);
        if (repulse) begin
            @(negedge clk);
            query      = randomLine();
            query[31:0] = ~q;
            queryValid = 1'b1;
            @(negedge clk);
            queryValid = 1'b0;
        end
        budget = 0;
        while (!(readCount == expReads && pendingCnt < 0) && budget < BUDGET) begin
            @(negedge clk);
            #2;
            budget++;
        end
        checkOutput({tag, ".finished"}, 32'(budget < BUDGET), 32'd1);
        repeat (4) @(negedge clk);
        #1;
        checkOutput({tag, ".reads"}, 32'(readCount), 32'(expReads));
        checkOutput({tag, ".hitTEST"}, 32'(hitTEST), 32'(expHit));
        checkOutput({tag, ".locStart"}, locationStart, expStart);
        checkOutput({tag, ".locEnd"}, locationEnd, expEnd);
    endtask

    task automatic fillOnes();
        for (int i = 0; i < NUM_LINES; i++) begin
            mem[i] = '1;
        end
    endtask

    task automatic loadBasicHit();
        logic [LINE_BITS-1:0] l;
        fillOnes();
        l = '1;
        l[31:0] = 32'h1234_abc0;
        mem[4] = l;
        mem[7] = l;
        l = '1;
        l[11:0] = 12'h123;
        mem[8] = l;
        l = '0;
        l[31:0] = 32'h1234_abcd;
        mem[9] = l;
    endtask

    initial begin
        bit hit;
        logic [31:0] expStart;
        int reads;
        logic [31:0] q;
        int ln;
        int off;

        rst        = 1'b1;
        queryValid = 1'b0;
        query      = '0;
        fillOnes();

        // Reset and idle behaviour.
        repeat (5) begin
            @(negedge clk);
            checkResetOutputs("rstHold");
        end
        rst = 1'b0;
        repeat (5) begin
            @(negedge clk);
            checkResetOutputs("idle");
        end

        // Near misses on lines 4, 7 and 8; first real hit at line 9.
        loadBasicHit();
        applyStimulus(32'h1234_abcd, 1'b1, 32'd4608, 10, 1'b0, "basicHit");

        // Query at bit 66 of line 2.
        fillOnes();
        mem[2] = '0;
        mem[2][66 +: 32] = 32'h1234_abcd;
        applyStimulus(32'h1234_abcd, 1'b1, 32'd1090, 3, 1'b0, "offset66");

        // Two matches in line 0; the lower offset wins.
        fillOnes();
        mem[0][10 +: 32]  = 32'h1234_abcd;
        mem[0][200 +: 32] = 32'h1234_abcd;
        applyStimulus(32'h1234_abcd, 1'b1, 32'd10, 1, 1'b0, "multi");

        // No hit anywhere.
        fillOnes();
        applyStimulus(32'h1234_abcd, 1'b0, 32'hFFFF_FFFF, NUM_LINES, 1'b0, "noHit");

        // queryValid re-pulsed while the first read is outstanding.
        loadBasicHit();
        applyStimulus(32'h1234_abcd, 1'b1, 32'd4608, 10, 1'b1, "repulse");

        // Reset in the middle of a scan.
        fillOnes();
        @(negedge clk);
        readCount  = 0;
        query      = '0;
        query[31:0] = 32'h1234_abcd;
        queryValid = 1'b1;
        @(negedge clk);
        queryValid = 1'b0;
        repeat (20) @(negedge clk);
        rst = 1'b1;
        #1;
        checkResetOutputs("midRst");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) begin
            @(negedge clk);
            checkResetOutputs("postRst");
        end

        // A hit followed by a second query with a different answer.
        fillOnes();
        mem[0][10 +: 32] = 32'h1234_abcd;
        applyStimulus(32'h1234_abcd, 1'b1, 32'd10, 1, 1'b0, "firstQ");
        fillOnes();
        mem[2] = '0;
        mem[2][66 +: 32] = 32'h1234_abcd;
        applyStimulus(32'h1234_abcd, 1'b1, 32'd1090, 3, 1'b0, "secondQ");

        // Random contents, random plants, random memory latency and stray valids.
        maxDelay = 3;
        junkEn   = 1'b1;
        for (int t = 0; t < 8; t++) begin
            q = $urandom;
            for (int i = 0; i < NUM_LINES; i++) begin
                mem[i] = randomLine();
            end
            ln  = int'($urandom_range(0, NUM_LINES - 1));
            off = 2 * int'($urandom_range(0, 240));
            case (t % 4)
                0: mem[ln][off +: 32] = q;
                1: begin
                    mem[ln][off +: 32] = q;
                    if (ln > 0) mem[ln-1][2 * int'($urandom_range(0, 239)) + 1 +: 32] = q;
                end
                2: mem[ln][2 * int'($urandom_range(0, 239)) + 1 +: 32] = q;
                default: begin
                end
            endcase
            refScan(q, hit, expStart, reads);
            applyStimulus(q, hit, expStart, reads, 1'b0, "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
